// File: rtl/cu_fsm_pkg.sv
// cu_fsm_pkg: shared opcode and control-state types for the otter control unit
package cu_fsm_pkg;
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_e;
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2,
    S_INTR  = 2'd3
  } state_e;
endpackage

// File: rtl/cu_fsm_if.sv
// cu_fsm_if: instruction/data handshake inputs and control strobes of the control unit
interface cu_fsm_if;
  import cu_fsm_pkg::*;
  opcode_e opcode;
  logic    intr;
  logic    imem_ready;
  logic    dmem_ready;
  logic    pc_write;
  logic    rf_wr_en;
  logic    imem_rden;
  logic    dmem_rden;
  logic    dmem_we;
  logic    intr_taken;
  logic    mem_err;
  modport master (
    output opcode, intr, imem_ready, dmem_ready,
    input  pc_write, rf_wr_en, imem_rden, dmem_rden, dmem_we, intr_taken, mem_err
  );
  modport slave (
    input  opcode, intr, imem_ready, dmem_ready,
    output pc_write, rf_wr_en, imem_rden, dmem_rden, dmem_we, intr_taken, mem_err
  );
endinterface

// File: rtl/cu_fsm.sv
// cu_fsm: multicycle control FSM issuing fetch/load/store/writeback/interrupt strobes
module cu_fsm
  import cu_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter bit INTR_EN     = 1'b1
) (
  input logic    clk,
  input logic    rst_n,
  cu_fsm_if.slave bus
);
  localparam int CW = $clog2(MEM_TIMEOUT) + 1;
  state_e          r_state, w_next;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic            w_wait, w_done, w_timeout;
  logic            w_pc, w_rf, w_irden, w_drden, w_we, w_itaken, w_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
    end
  always_comb begin
    w_next   = r_state;
    w_wait   = 1'b0;
    w_done   = 1'b0;
    w_pc     = 1'b0;
    w_rf     = 1'b0;
    w_irden  = 1'b0;
    w_drden  = 1'b0;
    w_we     = 1'b0;
    w_itaken = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irden = 1'b1;
        w_wait  = !bus.imem_ready;
        w_next  = bus.imem_ready ? S_EXEC : S_FETCH;
      end
      S_EXEC:
        case (bus.opcode)
          OP_LOAD: begin
            w_drden = 1'b1;
            w_next  = S_WB;
          end
          OP_STORE: begin
            w_we   = 1'b1;
            w_pc   = bus.dmem_ready;
            w_done = bus.dmem_ready;
            w_wait = !bus.dmem_ready;
          end
          OP_BRANCH: begin
            w_pc   = 1'b1;
            w_done = 1'b1;
          end
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG: begin
            w_pc   = 1'b1;
            w_rf   = 1'b1;
            w_done = 1'b1;
          end
          default: begin
            w_pc   = 1'b1;
            w_done = 1'b1;
          end
        endcase
      S_WB: begin
        w_drden = 1'b1;
        w_pc    = bus.dmem_ready;
        w_rf    = bus.dmem_ready;
        w_done  = bus.dmem_ready;
        w_wait  = !bus.dmem_ready;
      end
      default: begin
        w_itaken = 1'b1;
        w_pc     = 1'b1;
        w_next   = S_FETCH;
      end
    endcase
    if (w_done) w_next = (INTR_EN && bus.intr) ? S_INTR : S_FETCH;
    // ready in the limit cycle clears w_wait, so ready wins over the abort
    w_timeout = w_wait && (r_cnt == CW'(MEM_TIMEOUT - 1));
    if (w_timeout) begin
      w_next  = S_FETCH;
      w_err   = 1'b1;
      w_pc    = 1'b0;
      w_rf    = 1'b0;
      w_irden = 1'b0;
      w_drden = 1'b0;
      w_we    = 1'b0;
    end
    w_cnt = (w_next != r_state || w_timeout) ? '0 :
            (w_wait && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
  end
  assign bus.pc_write   = rst_n & w_pc;
  assign bus.rf_wr_en   = rst_n & w_rf;
  assign bus.imem_rden  = rst_n & w_irden;
  assign bus.dmem_rden  = rst_n & w_drden;
  assign bus.dmem_we    = rst_n & w_we;
  assign bus.intr_taken = rst_n & w_itaken;
  assign bus.mem_err    = rst_n & w_err;
endmodule

// File: tb/tb_cu_fsm.sv
// tb_cu_fsm: directed scoreboard bench for cu_fsm with INTR_EN on and off instances
module tb_cu_fsm;
  import cu_fsm_pkg::*;
  // expected vector order: {pc_write, rf_wr_en, imem_rden, dmem_rden, dmem_we, intr_taken, mem_err}
  localparam logic [6:0] Z   = 7'b0000000;
  localparam logic [6:0] F   = 7'b0010000;
  localparam logic [6:0] ALU = 7'b1100000;
  localparam logic [6:0] PCO = 7'b1000000;
  localparam logic [6:0] LDX = 7'b0001000;
  localparam logic [6:0] WBW = 7'b0001000;
  localparam logic [6:0] WBD = 7'b1101000;
  localparam logic [6:0] STW = 7'b0000100;
  localparam logic [6:0] STD = 7'b1000100;
  localparam logic [6:0] INT = 7'b1000010;
  localparam logic [6:0] ERR = 7'b0000001;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [6:0] q0[$];
  logic [6:0] q1[$];
  string      qn[$];
  opcode_e    nop_op;
  cu_fsm_if i0();
  cu_fsm_if i1();
  assign i1.opcode     = i0.opcode;
  assign i1.intr       = i0.intr;
  assign i1.imem_ready = i0.imem_ready;
  assign i1.dmem_ready = i0.dmem_ready;
  cu_fsm #(.MEM_TIMEOUT(16), .INTR_EN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
  cu_fsm #(.MEM_TIMEOUT(16), .INTR_EN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  always #5 clk = ~clk;
  function automatic logic [6:0] outs0();
    return {i0.pc_write, i0.rf_wr_en, i0.imem_rden, i0.dmem_rden, i0.dmem_we, i0.intr_taken, i0.mem_err};
  endfunction
  function automatic logic [6:0] outs1();
    return {i1.pc_write, i1.rf_wr_en, i1.imem_rden, i1.dmem_rden, i1.dmem_we, i1.intr_taken, i1.mem_err};
  endfunction
  always @(negedge clk)
    if (q0.size() != 0) begin
      logic [6:0] e0, e1, g0, g1;
      string nm;
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      nm = qn.pop_front();
      g0 = outs0();
      g1 = outs1();
      n_cmp += 2;
      if (g0 !== e0) begin
        n_bad++;
        $display("FAIL %s intr_en=1: got %b expected %b", nm, g0, e0);
      end
      if (g1 !== e1) begin
        n_bad++;
        $display("FAIL %s intr_en=0: got %b expected %b", nm, g1, e1);
      end
    end
  task automatic step(input logic rn, input opcode_e op, input logic it, input logic ir,
                      input logic dr, input logic [6:0] e0, input logic [6:0] e1, input string nm);
    rst_n         = rn;
    i0.opcode     = op;
    i0.intr       = it;
    i0.imem_ready = ir;
    i0.dmem_ready = dr;
    q0.push_back(e0);
    q1.push_back(e1);
    qn.push_back(nm);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    nop_op        = opcode_e'(7'b0000000);
    i0.opcode     = OP_IMM;
    i0.intr       = 1'b0;
    i0.imem_ready = 1'b0;
    i0.dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    step(0, OP_IMM, 0, 1, 0, Z, Z, "reset_held");
    step(1, OP_IMM, 0, 1, 0, F, F, "fetch_opimm");
    step(1, OP_IMM, 0, 1, 0, ALU, ALU, "exec_opimm");
    step(1, OP_LOAD, 0, 1, 0, F, F, "fetch_load");
    step(1, OP_LOAD, 0, 1, 0, LDX, LDX, "exec_load");
    for (int k = 0; k < 3; k++) step(1, OP_LOAD, 0, 1, 0, WBW, WBW, "wb_wait");
    step(1, OP_LOAD, 0, 1, 1, WBD, WBD, "wb_done");
    step(1, OP_BRANCH, 0, 0, 0, F, F, "fetch_wait");
    step(1, OP_BRANCH, 0, 1, 0, F, F, "fetch_branch");
    step(1, OP_BRANCH, 0, 1, 0, PCO, PCO, "exec_branch");
    step(1, nop_op, 0, 1, 0, F, F, "fetch_nop");
    step(1, nop_op, 0, 1, 0, PCO, PCO, "exec_nop");
    step(1, OP_STORE, 0, 1, 0, F, F, "fetch_store");
    for (int k = 0; k < 15; k++) step(1, OP_STORE, 0, 1, 0, STW, STW, "store_wait");
    step(1, OP_STORE, 0, 1, 0, ERR, ERR, "store_timeout");
    step(1, OP_STORE, 0, 1, 0, F, F, "refetch_store");
    for (int k = 0; k < 15; k++) step(1, OP_STORE, 0, 1, 0, STW, STW, "store_wait2");
    step(1, OP_STORE, 0, 1, 1, STD, STD, "store_ready_at_limit");
    step(1, OP_REG, 1, 1, 0, F, F, "fetch_add_intr");
    step(1, OP_REG, 1, 1, 0, ALU, ALU, "exec_add_intr");
    step(1, OP_REG, 1, 0, 0, INT, F, "intr_entry");
    step(1, OP_REG, 0, 0, 0, F, F, "after_intr");
    step(0, OP_LOAD, 0, 1, 0, Z, Z, "resync_reset");
    step(1, OP_LOAD, 0, 1, 0, F, F, "fetch_load2");
    step(1, OP_LOAD, 0, 1, 0, LDX, LDX, "exec_load2");
    step(1, OP_LOAD, 0, 1, 0, WBW, WBW, "wb_wait2");
    step(0, OP_LOAD, 0, 1, 1, Z, Z, "reset_mid_wb");
    step(0, OP_LOAD, 0, 1, 1, Z, Z, "reset_hold");
    for (int k = 0; k < 15; k++) step(1, OP_LOAD, 0, 0, 0, F, F, "fetch_resume_wait");
    step(1, OP_LOAD, 0, 0, 0, ERR, ERR, "fetch_timeout");
    step(1, OP_IMM, 0, 1, 0, F, F, "fetch_after_err");
    step(1, OP_IMM, 0, 1, 0, ALU, ALU, "exec_after_err");
    if (q0.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q0.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
